byteswap_axis_fifo: RTL and testbench
=====================================

Name: byteswap_axis_fifo

Overview:
- Synchronous AXI4-Stream FIFO placed directly downstream of the byteswap swapper stage, feeding the write-master.
- The swapper samples tready through registers, so it keeps presenting beats for several cycles after backpressure is applied.
- This block absorbs those in-flight beats: it drops s_axis_tready early, at a programmable threshold, and keeps headroom for the skid.
- Output is first-word-fall-through with a registered m_axis interface.

Parameters:
- C_AXIS_TDATA_WIDTH, 512, data width in bits; tkeep width is C_AXIS_TDATA_WIDTH/8.
- C_FIFO_DEPTH, 32, total capacity in beats, output register included; power of two, >= 8.
- C_PROG_FULL_THRESH, 24, fill level at or above which s_axis_tready deasserts; must be < C_FIFO_DEPTH.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tready  out  1  registered (fill_level < C_PROG_FULL_THRESH).
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  upstream data.
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8  upstream byte enables.
- s_axis_tlast  in  1  upstream end of packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  output data.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  output byte enables.
- m_axis_tlast  out  1  output end of packet.
- fill_level  out  $clog2(C_FIFO_DEPTH)+1  beats held, output register included.
- prog_full  out  1  registered (fill_level >= C_PROG_FULL_THRESH).

Behaviour:
- Reset: aresetn low clears the following immediately (async) and holds them clear.
  - m_axis_tvalid, s_axis_tready, prog_full, fill_level all 0.
  - Read/write pointers zeroed.
  - Data, keep and last outputs are don't-care.
- First rising aclk edge after aresetn rises: s_axis_tready=1.
- Push: s_axis_tvalid=1 AND (fill_level < C_FIFO_DEPTH OR pop this cycle).
  - Push does NOT depend on s_axis_tready; beats arriving after tready falls are still stored while space remains.
- Pop: m_axis_tvalid=1 AND m_axis_tready=1.
- Drop: s_axis_tvalid=1 while full with no pop; the beat is discarded.
  - No pointer or count change.
  - No corruption of stored data.
- Storage: tdata, tkeep and tlast are stored together as one entry. Order is preserved; no reordering, merging or tkeep filtering.
- Latency: a beat pushed into an empty FIFO appears on m_axis at the next edge (1-cycle fall-through).
- Output register:
  - Refilled from RAM on the same edge it is popped whenever the RAM is non-empty, giving 1 beat/cycle sustained throughput.
  - m_axis_tdata, tkeep and tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- fill_level update:
  - +1 on push only, -1 on pop only, unchanged on push+pop or idle.
  - Range 0..C_FIFO_DEPTH, never wraps.
- Pointers: $clog2(C_FIFO_DEPTH) bits, wrap modulo depth.
- s_axis_tready and prog_full are registered from the post-update fill_level, so they lag the count by one edge.
- Simultaneous push and pop when full: both happen and fill stays C_FIFO_DEPTH.
- Simultaneous push and pop when empty: cannot occur, since the output register is empty and there is no pop.
- Reset mid-stream: all contents discarded and m_axis_tvalid drops asynchronously. A partial packet is not completed.

Optional Feature:
- BYTESWAP_FIFO_OVERFLOW_EN defined adds two output ports:
  - overflow (1 bit): sticky, set on the first dropped beat, cleared only by reset.
  - drop_count (16 bits): increments per dropped beat and saturates at 0xFFFF.
  - Both are 0 at reset and update on the edge of the drop.
- Undefined: the ports do not exist and dropped beats are discarded silently. Core behaviour is identical.

Test Plan:
- Reset: aresetn=0 for 5 cycles with s_axis_tvalid=1 -> all outputs 0, nothing stored; after release, s_axis_tready=1 at first edge and fill_level=0.
- Single beat: tdata=0x...DEADBEEF, tkeep=all ones, tlast=1, m_axis_tready=1 -> m_axis_tvalid=1 on the next edge with identical data/keep/last; after the pop, fill_level=0.
- Threshold and skid: m_axis_tready=0, push 32 sequential beats (0..31) back-to-back.
  - s_axis_tready falls one edge after fill_level reaches 24 and prog_full=1.
  - All 32 beats are accepted and fill_level=32.
  - Then m_axis_tready=1 -> beats 0..31 emerge on 32 consecutive cycles, and s_axis_tready returns once fill_level < 24.
- Overflow: hold full (32), push 3 more beats 100..102 -> all dropped, fill stays 32, and the output order is still 0..31.
  - With BYTESWAP_FIFO_OVERFLOW_EN: overflow=1 and drop_count=3.
- Full with simultaneous push/pop: fill=32, m_axis_tready=1, push beat 200 every cycle for 4 cycles -> all accepted, fill stays 32, no drops, and 200 appears after the original 32 entries.
- Reset mid-stream: fill=10 with m_axis_tvalid=1, pulse aresetn low for 1 cycle -> m_axis_tvalid=0 immediately, fill_level=0, and the next pushed beat 0x55 is the first beat output.

Source files
------------

// File: rtl/byteswap_axis_fifo.sv
// byteswap_axis_fifo
// AXI4-Stream FIFO sitting between the byteswap swapper and the write-master.
// The swapper reacts to tready through registers, so s_axis_tready is dropped
// early at C_PROG_FULL_THRESH and the remaining space absorbs the skid beats.
// Beats arriving while completely full are discarded.
// Output is first-word-fall-through through a registered m_axis stage; the
// output register counts towards C_FIFO_DEPTH.
// Optional feature macro: BYTESWAP_FIFO_OVERFLOW_EN adds the overflow flag and
// the saturating drop_count port.
module byteswap_axis_fifo #(
   parameter int C_AXIS_TDATA_WIDTH = 512,
   parameter int C_FIFO_DEPTH       = 32,
   parameter int C_PROG_FULL_THRESH = 24
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                              s_axis_tlast,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                              m_axis_tlast,
   output logic [$clog2(C_FIFO_DEPTH):0]     fill_level,
   output logic                              prog_full
`ifdef BYTESWAP_FIFO_OVERFLOW_EN
   ,
   output logic                              overflow,
   output logic [15:0]                       drop_count
`endif
);

   localparam int KEEP_W  = C_AXIS_TDATA_WIDTH / 8;
   localparam int ENTRY_W = C_AXIS_TDATA_WIDTH + KEEP_W + 1;
   localparam int PTR_W   = $clog2(C_FIFO_DEPTH);
   localparam int FILL_W  = PTR_W + 1;

   localparam logic [FILL_W-1:0] DEPTH_F  = FILL_W'(C_FIFO_DEPTH);
   localparam logic [FILL_W-1:0] THRESH_F = FILL_W'(C_PROG_FULL_THRESH);

   // One slot of the array is never occupied because the output register
   // holds the head beat; keeping the array a full power of two lets the
   // pointers wrap naturally.
   logic [ENTRY_W-1:0] ram [C_FIFO_DEPTH];

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [FILL_W-1:0]  ram_count;
   logic [FILL_W-1:0]  fill_next;
   logic [ENTRY_W-1:0] in_entry;
   logic               pop;
   logic               push;
   logic               ram_empty;
   logic               out_load;
   logic               ram_rd;
   logic               ram_wr;
   logic               bypass;

   // Handshake decode: what moves on this edge and where it goes.
   always_comb begin
      pop       = m_axis_tvalid & m_axis_tready;
      push      = s_axis_tvalid & ((fill_level != DEPTH_F) | pop);
      ram_count = fill_level - FILL_W'(m_axis_tvalid);
      ram_empty = (ram_count == '0);
      out_load  = ~m_axis_tvalid | pop;
      ram_rd    = out_load & ~ram_empty;
      bypass    = out_load & ram_empty & push;
      ram_wr    = push & ~bypass;
      fill_next = fill_level + FILL_W'(push) - FILL_W'(pop);
      in_entry  = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   end

   // Control state: pointers, output valid, occupancy and the early-ready flags.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         m_axis_tvalid <= 1'b0;
         fill_level    <= '0;
         s_axis_tready <= 1'b0;
         prog_full     <= 1'b0;
      end else begin
         if (ram_wr)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (ram_rd)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (out_load)
            m_axis_tvalid <= ram_rd | bypass;
         fill_level    <= fill_next;
         s_axis_tready <= (fill_level < THRESH_F);
         prog_full     <= (fill_level >= THRESH_F);
      end
   end

   // Storage array write; contents need no reset since pointers gate reads.
   always_ff @(posedge aclk) begin
      if (ram_wr)
         ram[wr_ptr] <= in_entry;
   end

   // Output register: refilled from the array on a pop, or straight from the
   // input when the array is empty, and held while stalled.
   always_ff @(posedge aclk) begin
      if (ram_rd)
         {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= ram[rd_ptr];
      else if (bypass)
         {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= in_entry;
   end

`ifdef BYTESWAP_FIFO_OVERFLOW_EN
   logic drop;

   // A beat is lost only when valid is presented with no room and no pop.
   always_comb begin
      drop = s_axis_tvalid & ~push;
   end

   // Sticky overflow flag and saturating count of discarded beats.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_byteswap_axis_fifo.sv
// Testbench for byteswap_axis_fifo: directed steps followed by random traffic,
// checked against a queue-based model of the FIFO.
module tb_byteswap_axis_fifo;

   localparam int W     = 512;
   localparam int KW    = W / 8;
   localparam int DEPTH = 32;
   localparam int THR   = 24;
   localparam int FW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [W-1:0]  d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b1;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [W-1:0]  s_axis_tdata = '0;
   logic [KW-1:0] s_axis_tkeep = '0;
   logic          s_axis_tlast = 1'b0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic [W-1:0]  m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tlast;
   logic [FW-1:0] fill_level;
   logic          prog_full;
`ifdef BYTESWAP_FIFO_OVERFLOW_EN
   logic          overflow;
   logic [15:0]   drop_count;
`endif

   byteswap_axis_fifo #(
      .C_AXIS_TDATA_WIDTH (W),
      .C_FIFO_DEPTH       (DEPTH),
      .C_PROG_FULL_THRESH (THR)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .fill_level    (fill_level),
      .prog_full     (prog_full)
`ifdef BYTESWAP_FIFO_OVERFLOW_EN
      ,
      .overflow      (overflow),
      .drop_count    (drop_count)
`endif
   );

   always #5 aclk = ~aclk;

   // Reference model state
   beat_t q[$];
   logic  exp_tready = 1'b0;
   logic  exp_pf     = 1'b0;
   int    exp_drops  = 0;
   int    errors     = 0;
   int    checks     = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string ph);
      chk({ph, ".m_tvalid"}, W'(m_axis_tvalid), W'(q.size() != 0));
      if (q.size() != 0) begin
         chk({ph, ".m_tdata"}, m_axis_tdata, q[0].d);
         chk({ph, ".m_tkeep"}, W'(m_axis_tkeep), W'(q[0].k));
         chk({ph, ".m_tlast"}, W'(m_axis_tlast), W'(q[0].l));
      end
      chk({ph, ".fill"}, W'(fill_level), W'(q.size()));
      chk({ph, ".s_tready"}, W'(s_axis_tready), W'(exp_tready));
      chk({ph, ".prog_full"}, W'(prog_full), W'(exp_pf));
`ifdef BYTESWAP_FIFO_OVERFLOW_EN
      chk({ph, ".overflow"}, W'(overflow), W'(exp_drops != 0));
      chk({ph, ".drop_count"}, W'(drop_count), W'(exp_drops));
`endif
   endtask

   task automatic model_reset();
      q.delete();
      exp_tready = 1'b0;
      exp_pf     = 1'b0;
      exp_drops  = 0;
   endtask

   // One clock: predict from inputs, advance, then compare just after the edge.
   task automatic tick(input string ph);
      bit    pop, acc, drp, rdy_n;
      beat_t b;
      pop   = (q.size() != 0) && m_axis_tready;
      acc   = s_axis_tvalid && ((q.size() < DEPTH) || pop);
      drp   = s_axis_tvalid && !acc;
      rdy_n = (q.size() < THR);
      b     = '{d: s_axis_tdata, k: s_axis_tkeep, l: s_axis_tlast};
      @(posedge aclk);
      #1;
      if (!aresetn) begin
         model_reset();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(b);
         if (drp && exp_drops < 65535) exp_drops++;
         exp_tready = rdy_n;
         exp_pf     = !rdy_n;
      end
      check_outputs(ph);
   endtask

   task automatic set_beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
      s_axis_tdata = d;
      s_axis_tkeep = k;
      s_axis_tlast = l;
   endtask

   function automatic logic [W-1:0] rand_data();
      logic [W-1:0] r;
      for (int j = 0; j < W / 32; j++) r[j*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [KW-1:0] rand_keep();
      logic [KW-1:0] r;
      r[31:0]  = $urandom();
      r[63:32] = $urandom();
      return r;
   endfunction

   initial begin
      logic [W-1:0] dbeef;
      int           bias;

      // Reset held with upstream valid asserted
      #1 aresetn = 1'b0;
      model_reset();
      s_axis_tvalid = 1'b1;
      set_beat(W'(32'h1234_5678), '1, 1'b1);
      for (int i = 0; i < 5; i++) tick("reset");

      // Release: ready appears on the first edge
      aresetn       = 1'b1;
      s_axis_tvalid = 1'b0;
      tick("release");
      chk("release.tready_direct", W'(s_axis_tready), W'(1));

      // Single beat with 1-cycle fall-through
      dbeef         = rand_data();
      dbeef[31:0]   = 32'hDEAD_BEEF;
      set_beat(dbeef, '1, 1'b1);
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
      tick("single_push");
      chk("single.data_direct", m_axis_tdata, dbeef);
      s_axis_tvalid = 1'b0;
      tick("single_pop");
      chk("single.fill_direct", W'(fill_level), W'(0));

      // Threshold and skid: 32 back-to-back beats into a stalled output
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         set_beat(W'(i), rand_keep(), (i % 8) == 7);
         tick("fill");
      end
      chk("fill.level32", W'(fill_level), W'(32));
      chk("fill.tready_low", W'(s_axis_tready), W'(0));
      chk("fill.prog_full", W'(prog_full), W'(1));

      // Overflow: three more beats are discarded
      for (int i = 100; i < 103; i++) begin
         set_beat(W'(i), '1, 1'b0);
         tick("overflow");
      end
      chk("overflow.level32", W'(fill_level), W'(32));
      chk("overflow.head0", m_axis_tdata, W'(0));

      // Full with simultaneous push and pop
      m_axis_tready = 1'b1;
      set_beat(W'(200), '1, 1'b1);
      for (int i = 0; i < 4; i++) tick("full_pp");
      chk("full_pp.level32", W'(fill_level), W'(32));
      chk("full_pp.head4", m_axis_tdata, W'(4));

      // Drain: remaining originals then the four 200s, one per cycle
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 36; i++) tick("drain");
      chk("drain.empty", W'(fill_level), W'(0));

      // Reset mid-stream with 10 beats held
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_beat(W'(300 + i), rand_keep(), 1'b0);
         tick("mid_fill");
      end
      s_axis_tvalid = 1'b0;
      aresetn       = 1'b0;
      model_reset();
      #1;
      chk("mid_rst.async_tvalid", W'(m_axis_tvalid), W'(0));
      check_outputs("mid_rst");
      tick("mid_rst_hold");
      aresetn = 1'b1;
      tick("mid_rst_release");
      set_beat(W'(8'h55), '1, 1'b1);
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
      tick("mid_first");
      chk("mid_first.data55", m_axis_tdata, W'(8'h55));
      s_axis_tvalid = 1'b0;
      tick("mid_drain");

      // Random traffic with varying downstream pressure
      for (int ph = 0; ph < 6; ph++) begin
         bias = (ph % 3 == 0) ? 15 : ((ph % 3 == 1) ? 85 : 50);
         for (int i = 0; i < 100; i++) begin
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            set_beat(rand_data(), rand_keep(), $urandom_range(0, 1) == 1);
            m_axis_tready = ($urandom_range(0, 99) < bias);
            tick("random");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
